mem_write_buffer: RTL and testbench
===================================

Name: mem_write_buffer

Overview:
Posted write-through buffer between the cache controller's main-memory port and main memory (DRAM model or controller). It absorbs the controller's single-word write-through stores into a FIFO and acknowledges them immediately, then drains them to memory in order. Block-refill reads pass through only after the FIFO has fully drained, which preserves read-after-write ordering.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
ADDR_W, 32, address width
WORD_W, 32, write data width
BLOCK_W, 512, refill block width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cc_addr  in  ADDR_W  controller request address
cc_wdata  in  WORD_W  controller write word
cc_read_req  in  1  block read request (level, held until cc_ready)
cc_write_req  in  1  word write request (level, held until cc_ready)
cc_rdata  out  BLOCK_W  refill block to controller
cc_ready  out  1  one-cycle completion pulse to controller
mem_addr  out  ADDR_W  memory address
mem_wdata  out  WORD_W  memory write word
mem_read_req  out  1  one-cycle read request pulse
mem_write_req  out  1  one-cycle write request pulse
mem_rdata  in  BLOCK_W  memory read block
mem_ready  in  1  one-cycle memory completion pulse
wb_count  out  $clog2(DEPTH)+1  occupied entries
wb_full  out  1  wb_count==DEPTH
wb_empty  out  1  wb_count==0

Behaviour:
- Single clock domain. Reset is synchronous, active-high. Every output resets to 0, except wb_empty, which resets to 1. FIFO pointers are cleared and both FSMs return to idle.
- Upstream FSM states: U_IDLE, U_ACK, U_RD_WAIT_EMPTY, U_RD_WAIT.
  - U_IDLE with cc_write_req and !wb_full: push {cc_addr, cc_wdata}, set cc_ready<=1, go to U_ACK.
  - U_IDLE with cc_write_req and wb_full: no push, no ack, stay in U_IDLE. The request stays pending until a slot frees.
  - U_IDLE with cc_read_req (and no cc_write_req): latch cc_addr, go to U_RD_WAIT_EMPTY.
  - If cc_read_req and cc_write_req are both high, write wins. This combination is illegal from the controller, but the behaviour is defined.
  - U_ACK: cc_ready<=0, return to U_IDLE. Requests are ignored in U_ACK because upstream deasserts its request in the cycle after cc_ready.
  - U_RD_WAIT_EMPTY: when wb_empty and the downstream FSM is in D_IDLE, hand the read to the downstream FSM and go to U_RD_WAIT. The read is never issued ahead of queued writes.
  - U_RD_WAIT: on mem_ready, cc_rdata<=mem_rdata and cc_ready<=1 (one cycle), then go to U_ACK. cc_rdata holds its value until the next read completes.
- Downstream FSM states: D_IDLE, D_WR_WAIT, D_RD_WAIT.
  - D_IDLE with FIFO non-empty: drive mem_addr/mem_wdata from the FIFO head, pulse mem_write_req for 1 cycle, go to D_WR_WAIT.
  - D_IDLE with a read handoff: mem_addr<=latched address, pulse mem_read_req, go to D_RD_WAIT.
  - D_WR_WAIT: mem_addr/mem_wdata stay stable until mem_ready. On mem_ready, pop the head and return to D_IDLE.
  - D_RD_WAIT: on mem_ready, return to D_IDLE.
  - At most one memory transaction is outstanding. A minimum of one D_IDLE cycle separates transactions.
- Write ack latency: cc_ready is high in the cycle after the edge that accepted the write.
- Read latency, buffer empty: one edge to reach U_RD_WAIT_EMPTY, one edge to issue mem_read_req, then the memory latency, then cc_ready one cycle after mem_ready.
- Push and pop in the same cycle leave wb_count unchanged. Pointers wrap modulo DEPTH.
- A push is permitted while full only if a pop occurs in the same cycle. This optimisation is not required; the baseline design stalls.
- mem_ready while both FSMs are idle (e.g. stale after reset) is ignored.
- Reset mid-operation: queued writes are discarded, the outstanding transaction is abandoned, and no further requests are issued.

Test Plan:
1. Reset: hold rst 2 cycles -> all outputs 0, wb_empty=1, wb_count=0; no mem_*_req pulses.
2. Single write (addr 0x00002000, data 0xCAFEBABE), memory latency 3 cycles -> cc_ready pulses the cycle after acceptance. The next cycle mem_write_req pulses with mem_addr=0x00002000, mem_wdata=0xCAFEBABE. wb_count goes 1->0 after mem_ready.
3. Overflow: hold mem_ready=0, issue 5 writes to 0x1000,0x1004,0x1008,0x100C,0x1010 -> 4 acks, wb_full=1, 5th unacked. Then release memory -> 5th acked after the first pop. Drain order matches issue order.
4. RAW ordering: write 0x1000=0xDEADBEEF, then immediately read 0x1000 -> mem_read_req occurs strictly after the write's mem_ready. cc_rdata[31:0]=0xDEADBEEF.
5. Simultaneous push/pop: with wb_count=2, a write is accepted in the same cycle as a drain mem_ready -> wb_count stays 2.
6. Reset mid-drain: 3 writes queued, rst asserted while mem_write_req is outstanding -> wb_count=0, and a late mem_ready is ignored. No mem_write_req pulses follow until new writes arrive.

Source files
------------

// File: rtl/mem_write_buffer.sv
// mem_write_buffer: posted write-through buffer in front of main memory.
// Writes are acked into a FIFO and drained in order; reads wait for drain.
module mem_write_buffer #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 32,
  parameter int WORD_W  = 32,
  parameter int BLOCK_W = 512
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      cc_addr,
  input  logic [WORD_W-1:0]      cc_wdata,
  input  logic                   cc_read_req,
  input  logic                   cc_write_req,
  output logic [BLOCK_W-1:0]     cc_rdata,
  output logic                   cc_ready,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [WORD_W-1:0]      mem_wdata,
  output logic                   mem_read_req,
  output logic                   mem_write_req,
  input  logic [BLOCK_W-1:0]     mem_rdata,
  input  logic                   mem_ready,
  output logic [$clog2(DEPTH):0] wb_count,
  output logic                   wb_full,
  output logic                   wb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    U_IDLE,
    U_ACK,
    U_RD_WAIT_EMPTY,
    U_RD_WAIT
  } u_state_e;

  typedef enum logic [1:0] {
    D_IDLE,
    D_WR_WAIT,
    D_RD_WAIT
  } d_state_e;

  u_state_e u_state_q, u_state_d;
  d_state_e d_state_q, d_state_d;

  logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
  logic [WORD_W-1:0] fifo_data_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [BLOCK_W-1:0] cc_rdata_q, cc_rdata_d;
  logic               cc_ready_q, cc_ready_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               mem_rd_q, mem_rd_d;
  logic               mem_wr_q, mem_wr_d;

  logic push;
  logic pop;
  logic full;
  logic empty;
  logic rd_go;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // A read may only leave once every queued write has drained.
  assign rd_go = (u_state_q == U_RD_WAIT_EMPTY) &&
                 empty && (d_state_q == D_IDLE);

  // Upstream FSM: accept writes, hold reads until the FIFO is empty.
  always_comb begin
    u_state_d  = u_state_q;
    cc_ready_d = 1'b0;
    cc_rdata_d = cc_rdata_q;
    rd_addr_d  = rd_addr_q;
    push       = 1'b0;
    unique case (u_state_q)
      U_IDLE: begin
        if (cc_write_req) begin
          if (!full) begin
            push       = 1'b1;
            cc_ready_d = 1'b1;
            u_state_d  = U_ACK;
          end
        end else if (cc_read_req) begin
          rd_addr_d = cc_addr;
          u_state_d = U_RD_WAIT_EMPTY;
        end
      end
      U_ACK: begin
        u_state_d = U_IDLE;
      end
      U_RD_WAIT_EMPTY: begin
        if (rd_go) begin
          u_state_d = U_RD_WAIT;
        end
      end
      U_RD_WAIT: begin
        if (mem_ready && (d_state_q == D_RD_WAIT)) begin
          cc_rdata_d = mem_rdata;
          cc_ready_d = 1'b1;
          u_state_d  = U_ACK;
        end
      end
      default: begin
        u_state_d = U_IDLE;
      end
    endcase
  end

  // Downstream FSM: one memory transaction at a time, writes first.
  always_comb begin
    d_state_d   = d_state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_d    = 1'b0;
    mem_rd_d    = 1'b0;
    pop         = 1'b0;
    unique case (d_state_q)
      D_IDLE: begin
        if (!empty) begin
          mem_addr_d  = fifo_addr_q[rd_ptr_q];
          mem_wdata_d = fifo_data_q[rd_ptr_q];
          mem_wr_d    = 1'b1;
          d_state_d   = D_WR_WAIT;
        end else if (rd_go) begin
          mem_addr_d = rd_addr_q;
          mem_rd_d   = 1'b1;
          d_state_d  = D_RD_WAIT;
        end
      end
      D_WR_WAIT: begin
        if (mem_ready) begin
          pop       = 1'b1;
          d_state_d = D_IDLE;
        end
      end
      D_RD_WAIT: begin
        if (mem_ready) begin
          d_state_d = D_IDLE;
        end
      end
      default: begin
        d_state_d = D_IDLE;
      end
    endcase
  end

  // FIFO pointer and occupancy update; pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // FIFO storage; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= cc_addr;
      fifo_data_q[wr_ptr_q] <= cc_wdata;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      u_state_q   <= U_IDLE;
      d_state_q   <= D_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_addr_q   <= '0;
      cc_rdata_q  <= '0;
      cc_ready_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      u_state_q   <= u_state_d;
      d_state_q   <= d_state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_addr_q   <= rd_addr_d;
      cc_rdata_q  <= cc_rdata_d;
      cc_ready_q  <= cc_ready_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  assign cc_rdata      = cc_rdata_q;
  assign cc_ready      = cc_ready_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_read_req  = mem_rd_q;
  assign mem_write_req = mem_wr_q;
  assign wb_count      = count_q;
  assign wb_full       = full;
  assign wb_empty      = empty;

endmodule

// File: tb/tb_mem_write_buffer.sv
// tb_mem_write_buffer: directed bench for the posted write buffer.
// Table of single transactions plus hand sequences for multi-cycle cases.
module tb_mem_write_buffer;

  localparam int BW = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   cc_addr;
  logic [31:0]   cc_wdata;
  logic          cc_read_req;
  logic          cc_write_req;
  logic [BW-1:0] cc_rdata;
  logic          cc_ready;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_read_req;
  logic          mem_write_req;
  logic [BW-1:0] mem_rdata = '0;
  logic          mem_ready;
  logic          mem_ready_r = 1'b0;
  logic          inj_ready = 1'b0;
  logic [2:0]    wb_count;
  logic          wb_full;
  logic          wb_empty;

  assign mem_ready = mem_ready_r | inj_ready;

  mem_write_buffer #(
    .DEPTH(4), .ADDR_W(32), .WORD_W(32), .BLOCK_W(BW)
  ) dut (
    .clk(clk), .rst(rst),
    .cc_addr(cc_addr), .cc_wdata(cc_wdata),
    .cc_read_req(cc_read_req), .cc_write_req(cc_write_req),
    .cc_rdata(cc_rdata), .cc_ready(cc_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .wb_count(wb_count), .wb_full(wb_full), .wb_empty(wb_empty)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;

  // memory model state
  int          mem_lat = 3;
  bit          mem_hold = 1'b0;
  bit          pend = 1'b0;
  bit          p_rd;
  logic [31:0] p_addr;
  logic [31:0] p_data;
  int          p_cnt;
  int          wr_req_cyc = 0;
  int          rd_req_cyc = 0;
  logic [31:0] tbmem [logic [31:0]];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  bit          log_rd [$];
  int          done_cyc [$];
  logic [31:0] done_addr [$];
  logic [31:0] done_data [$];

  function automatic logic [BW-1:0] mkblk(logic [31:0] a, logic [31:0] w);
    return {{15{a ^ 32'h5A5A5A5A}}, w};
  endfunction

  function automatic logic [31:0] rd_word(logic [31:0] a);
    return tbmem.exists(a) ? tbmem[a] : 32'h0;
  endfunction

  // Memory responder, acting 2 time units after each rising edge.
  always begin
    @(posedge clk);
    #2;
    mem_ready_r = 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else if (mem_write_req || mem_read_req) begin
      pend   = 1'b1;
      p_rd   = mem_read_req;
      p_addr = mem_addr;
      p_data = mem_wdata;
      p_cnt  = mem_lat;
      if (mem_read_req) rd_req_cyc = cyc;
      else wr_req_cyc = cyc;
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_read_req ? 32'h0 : mem_wdata);
      log_rd.push_back(mem_read_req);
    end else if (pend && !mem_hold) begin
      if (p_cnt <= 1) begin
        pend        = 1'b0;
        mem_ready_r = 1'b1;
        if (p_rd) begin
          mem_rdata = mkblk(p_addr, rd_word(p_addr));
        end else begin
          tbmem[p_addr] = p_data;
          done_cyc.push_back(cyc);
          done_addr.push_back(mem_addr);
          done_data.push_back(mem_wdata);
        end
      end else begin
        p_cnt--;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkblk(string nm, logic [BW-1:0] act, logic [BW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rst_outs(string tag);
    chkblk({tag, "_rdata"}, cc_rdata, '0);
    chk({tag, "_ready"}, 32'(cc_ready), 0);
    chk({tag, "_maddr"}, mem_addr, 0);
    chk({tag, "_mwdata"}, mem_wdata, 0);
    chk({tag, "_mrd"}, 32'(mem_read_req), 0);
    chk({tag, "_mwr"}, 32'(mem_write_req), 0);
    chk({tag, "_count"}, 32'(wb_count), 0);
    chk({tag, "_full"}, 32'(wb_full), 0);
    chk({tag, "_empty"}, 32'(wb_empty), 1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int ack_c);
    cc_addr = a;
    cc_wdata = d;
    cc_write_req = 1'b1;
    lat = -1;
    ack_c = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (cc_ready) begin
        lat = i;
        ack_c = cyc;
        break;
      end
    end
    cc_write_req = 1'b0;
    if (lat < 0) begin
      nchk++;
      nerr++;
      $display("FAIL write_timeout: no ack for addr %0h", a);
    end
  endtask

  task automatic do_read(input logic [31:0] a, output int lat);
    cc_addr = a;
    cc_read_req = 1'b1;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (cc_ready) begin
        lat = i;
        break;
      end
    end
    cc_read_req = 1'b0;
    if (lat < 0) begin
      nchk++;
      nerr++;
      $display("FAIL read_timeout: no ack for addr %0h", a);
    end
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wb_empty && !pend && !cc_ready && !mem_ready_r) break;
    end
    if (i == 300) begin
      nchk++;
      nerr++;
      $display("FAIL drain_timeout: count %0d", wb_count);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_log(string nm, int idx, logic [31:0] a,
                         logic [31:0] d, bit rd);
    nchk++;
    if (log_addr.size() <= idx) begin
      nerr++;
      $display("FAIL %s_missing: log size %0d need %0d", nm,
               log_addr.size(), idx + 1);
    end else if (log_addr[idx] !== a || log_data[idx] !== d ||
                 log_rd[idx] !== rd) begin
      nerr++;
      $display("FAIL %s: got a=%0h d=%0h rd=%0d expected a=%0h d=%0h rd=%0d",
               nm, log_addr[idx], log_data[idx], log_rd[idx], a, d, rd);
    end
  endtask

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
    int          lat;
    int          exp_lat;
  } vec_t;

  vec_t vt [7];

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int ack_c;
    int n0;
    int idx;
    int acks;
    int reqs;

    vt[0] = '{1'b0, 32'h00002000, 32'hCAFEBABE, 3, 1};
    vt[1] = '{1'b0, 32'h00002004, 32'h12345678, 1, 1};
    vt[2] = '{1'b1, 32'h00002000, 32'hCAFEBABE, 3, 6};
    vt[3] = '{1'b1, 32'h00002004, 32'h12345678, 1, 4};
    vt[4] = '{1'b1, 32'h00003000, 32'h00000000, 2, 5};
    vt[5] = '{1'b0, 32'h00003000, 32'h0F0F0F0F, 5, 1};
    vt[6] = '{1'b1, 32'h00003000, 32'h0F0F0F0F, 5, 8};

    rst = 1'b1;
    cc_addr = '0;
    cc_wdata = '0;
    cc_read_req = 1'b0;
    cc_write_req = 1'b0;

    // reset state over two cycles
    @(negedge clk);
    chk_rst_outs("rst1");
    @(negedge clk);
    chk_rst_outs("rst2");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // table of single transactions from an idle buffer
    for (int k = 0; k < 7; k++) begin
      mem_lat = vt[k].lat;
      n0 = log_addr.size();
      if (!vt[k].rd) begin
        do_write(vt[k].addr, vt[k].data, lat, ack_c);
        chk($sformatf("v%0d_ack_lat", k), lat, vt[k].exp_lat);
        chk($sformatf("v%0d_cnt_ack", k), 32'(wb_count), 1);
        wait_idle();
        chk($sformatf("v%0d_req_cyc", k), wr_req_cyc, ack_c + 1);
        chk_log($sformatf("v%0d_log", k), n0, vt[k].addr, vt[k].data, 1'b0);
        chk($sformatf("v%0d_done_a", k), done_addr[$], vt[k].addr);
        chk($sformatf("v%0d_done_d", k), done_data[$], vt[k].data);
        chk($sformatf("v%0d_cnt_end", k), 32'(wb_count), 0);
      end else begin
        do_read(vt[k].addr, lat);
        chk($sformatf("v%0d_rd_lat", k), lat, vt[k].exp_lat);
        chkblk($sformatf("v%0d_rdata", k), cc_rdata,
               mkblk(vt[k].addr, vt[k].data));
        wait_idle();
        chk_log($sformatf("v%0d_log", k), n0, vt[k].addr, 32'h0, 1'b1);
        chkblk($sformatf("v%0d_rdata_hold", k), cc_rdata,
               mkblk(vt[k].addr, vt[k].data));
      end
    end

    // overflow: memory stalled, fifth write must wait for a pop
    mem_lat = 1;
    mem_hold = 1'b1;
    n0 = log_addr.size();
    for (int i = 0; i < 4; i++) begin
      do_write(32'h1000 + 32'(4 * i), 32'hA0000000 + 32'(i), lat, ack_c);
      chk($sformatf("ovf_ack_lat%0d", i), lat, 1);
      @(negedge clk);
    end
    chk("ovf_count", 32'(wb_count), 4);
    chk("ovf_full", 32'(wb_full), 1);
    cc_addr = 32'h1010;
    cc_wdata = 32'hA0000004;
    cc_write_req = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (cc_ready) acks++;
    end
    chk("ovf_no_ack", acks, 0);
    chk("ovf_count_hold", 32'(wb_count), 4);
    idx = done_cyc.size();
    mem_hold = 1'b0;
    ack_c = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cc_ready) begin
        ack_c = cyc;
        break;
      end
    end
    cc_write_req = 1'b0;
    chk("ovf_ack_after_pop",
        32'(ack_c >= 0 && done_cyc.size() > idx && ack_c > done_cyc[idx]), 1);
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      chk_log($sformatf("ovf_order%0d", i), n0 + i,
              32'h1000 + 32'(4 * i), 32'hA0000000 + 32'(i), 1'b0);
    end

    // read-after-write: the read must follow the write's completion
    mem_lat = 3;
    n0 = log_addr.size();
    do_write(32'h1000, 32'hDEADBEEF, lat, ack_c);
    do_read(32'h1000, lat);
    chk("raw_rdata", cc_rdata[31:0], 32'hDEADBEEF);
    chk("raw_order", 32'(rd_req_cyc > done_cyc[$]), 1);
    wait_idle();
    chk_log("raw_log_wr", n0, 32'h1000, 32'hDEADBEEF, 1'b0);
    chk_log("raw_log_rd", n0 + 1, 32'h1000, 32'h0, 1'b1);

    // push and pop on the same edge with two entries queued
    mem_lat = 1;
    mem_hold = 1'b1;
    @(negedge clk);
    n0 = log_addr.size();
    do_write(32'h4000, 32'h00000001, lat, ack_c);
    do_write(32'h4004, 32'h00000002, lat, ack_c);
    chk("pp_count_pre", 32'(wb_count), 2);
    mem_hold = 1'b0;
    do_write(32'h4008, 32'h00000003, lat, ack_c);
    chk("pp_count", 32'(wb_count), 2);
    chk("pp_same_edge", ack_c, done_cyc[$] + 1);
    wait_idle();
    chk_log("pp_order0", n0, 32'h4000, 32'h1, 1'b0);
    chk_log("pp_order1", n0 + 1, 32'h4004, 32'h2, 1'b0);
    chk_log("pp_order2", n0 + 2, 32'h4008, 32'h3, 1'b0);

    // reset while a drain is outstanding
    mem_lat = 2;
    mem_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_write(32'h6000 + 32'(4 * i), 32'hB0000000 + 32'(i), lat, ack_c);
      @(negedge clk);
    end
    chk("mr_count_pre", 32'(wb_count), 3);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mr_count", 32'(wb_count), 0);
    chk("mr_empty", 32'(wb_empty), 1);
    chk("mr_mwr", 32'(mem_write_req), 0);
    rst = 1'b0;
    mem_hold = 1'b0;
    n0 = log_addr.size();
    inj_ready = 1'b1;
    @(negedge clk);
    inj_ready = 1'b0;
    acks = 0;
    reqs = 0;
    repeat (10) begin
      @(negedge clk);
      if (cc_ready) acks++;
      if (mem_write_req || mem_read_req) reqs++;
    end
    chk("mr_no_reqs", reqs, 0);
    chk("mr_no_acks", acks, 0);
    chk("mr_log", log_addr.size(), n0);
    chk("mr_count_stale", 32'(wb_count), 0);
    do_write(32'h5000, 32'h55AA55AA, lat, ack_c);
    chk("mr_new_ack_lat", lat, 1);
    wait_idle();
    chk("mr_new_log_size", log_addr.size(), n0 + 1);
    chk_log("mr_new_log", n0, 32'h5000, 32'h55AA55AA, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
